// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - signal bundle between mem_stage and EX/WB/data-SRAM/ID
// Parameters: ES_TO_MS_BUS_WD (EX->MS bundle width), MS_TO_WS_BUS_WD (MS->WB bundle width).
// Modports:
//   master - the memory stage: takes EX bundle, SRAM response, flush, ws_allowin;
//            drives ms_allowin, WB bundle, stall/forward buses, hazard flags
//   slave  - the surrounding pipeline, directions mirrored
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 170,
    parameter int MS_TO_WS_BUS_WD = 130
);
    logic                       flush;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [9:0]                 stall_ms_bus;
    logic [32:0]                forward_ms_bus;
    logic                       ms_exc_eret;
    logic                       ms_entryhi_hazard;

    modport master (
        input  flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret, ms_entryhi_hazard
    );

    modport slave (
        output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret, ms_entryhi_hazard
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: load wait, data alignment, WB handoff, flush discard
// Optional feature macro: MEM_LWLR_EN (lwl/lwr shift-and-mask; when undefined they act as lw).
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   ms     mem_stage_if.master: EX bundle in, WB bundle out, data-SRAM response,
//          ID stall/forward buses, ms_exc_eret, ms_entryhi_hazard
// Bundle fields below bit 130: [76] entryhi_wen [75] eret [74] exc [73] res_from_cp0
//   [72:69] gr_we [68:64] dest [63:32] ALU result/address [31:0] pc; [129:77] pass through.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 170,
    parameter int MS_TO_WS_BUS_WD = 130,
    parameter int DISCARD_W       = 2
) (
    input logic         clk,
    input logic         reset,
    mem_stage_if.master ms
);
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

    // Held bundle: load_op plus the 130 WB-bound bits; rt_value and mem_req are not needed later.
    localparam int HOLD_W = 137;

    state_t               state_q, state_d;
    logic [DISCARD_W-1:0] disc_q, disc_d;
    logic [HOLD_W-1:0]    bus_q;
    logic [31:0]          rdata_q;

    logic       allowin, accept, ready_go, valid;
    logic       resp_live, disc_inc, disc_dec;
    state_t     accept_state;
    logic       unused_rt;

    logic [6:0]  load_op;
    logic        entryhi_wen, eret, exc, res_from_cp0;
    logic [3:0]  gr_we_in;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [1:0]  addr;
    logic [31:0] rdata_shr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] result;
    logic [3:0]  gr_we;

    assign load_op      = bus_q[136:130];
    assign entryhi_wen  = bus_q[76];
    assign eret         = bus_q[75];
    assign exc          = bus_q[74];
    assign res_from_cp0 = bus_q[73];
    assign gr_we_in     = bus_q[72:69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign addr         = alu_result[1:0];
    assign unused_rt    = ^ms.es_to_ms_bus[ES_TO_MS_BUS_WD-9:130];

    assign ready_go = (state_q == S_READY);
    assign valid    = (state_q != S_EMPTY);
    assign allowin  = (state_q == S_EMPTY) || (ready_go && ms.ws_allowin);
    assign accept   = ms.es_to_ms_valid && allowin && !ms.flush;

    // A faulting instruction never had its request issued, so it must not wait for data.
    assign accept_state = (ms.es_to_ms_bus[ES_TO_MS_BUS_WD-8] && !ms.es_to_ms_bus[74])
                          ? S_WAIT : S_READY;

    // Responses arrive in order: while stale requests are outstanding, the oldest data_ok is theirs.
    assign resp_live = (state_q == S_WAIT) && ms.data_sram_data_ok && (disc_q == '0);
    assign disc_dec  = ms.data_sram_data_ok && (disc_q != '0);
    // Flushing a waiting load leaves its response in flight unless it was just consumed.
    assign disc_inc  = ms.flush && (state_q == S_WAIT) && !resp_live;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = accept_state;
            S_WAIT: begin
                if (ms.flush)      state_d = S_EMPTY;
                else if (resp_live) state_d = S_READY;
            end
            S_READY: begin
                if (ms.flush)           state_d = S_EMPTY;
                else if (accept)        state_d = accept_state;
                else if (ms.ws_allowin) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        disc_d = disc_q;
        if (disc_inc && !disc_dec) begin
            if (disc_q != {DISCARD_W{1'b1}}) disc_d = disc_q + DISCARD_W'(1);
        end else if (disc_dec && !disc_inc) begin
            disc_d = disc_q - DISCARD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            disc_q  <= '0;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
            if (accept)    bus_q   <= {ms.es_to_ms_bus[ES_TO_MS_BUS_WD-1 -: 7], ms.es_to_ms_bus[129:0]};
            if (resp_live) rdata_q <= ms.data_sram_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(disc_inc && !disc_dec && (disc_q == {DISCARD_W{1'b1}})));

    assign rdata_shr = rdata_q >> {addr, 3'b000};
    assign ld_byte   = rdata_shr[7:0];
    assign ld_half   = addr[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        result = alu_result;
        gr_we  = gr_we_in;
        if (load_op[0]) begin
            result = {{24{ld_byte[7]}}, ld_byte};
            gr_we  = 4'hf;
        end else if (load_op[1]) begin
            result = {24'h0, ld_byte};
            gr_we  = 4'hf;
        end else if (load_op[2]) begin
            result = {{16{ld_half[15]}}, ld_half};
            gr_we  = 4'hf;
        end else if (load_op[3]) begin
            result = {16'h0, ld_half};
            gr_we  = 4'hf;
`ifdef MEM_LWLR_EN
        end else if (load_op[4]) begin
            result = rdata_q;
            gr_we  = 4'hf;
        end else if (load_op[5]) begin
            // lwl: the addressed byte lands in the top lane; WB keeps the lower lanes of rt.
            result = rdata_q << {~addr, 3'b000};
            gr_we  = 4'b1111 << ~addr;
        end else if (load_op[6]) begin
            result = rdata_shr;
            gr_we  = 4'b1111 >> addr;
`else
        end else if (|load_op[6:4]) begin
            result = rdata_q;
            gr_we  = 4'hf;
`endif
        end
        if (exc) gr_we = 4'h0;
    end

    assign ms.ms_allowin        = allowin;
    assign ms.ms_to_ws_valid    = ready_go && !ms.flush;
    assign ms.ms_to_ws_bus      = MS_TO_WS_BUS_WD'({bus_q[129:73], gr_we, dest, result, bus_q[31:0]});
    assign ms.stall_ms_bus      = {valid && (|gr_we), gr_we & {4{valid}}, dest};
    assign ms.forward_ms_bus    = {ready_go && !res_from_cp0, result};
    assign ms.ms_exc_eret       = valid && (exc || eret);
    assign ms.ms_entryhi_hazard = valid && entryhi_wen;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage: directed cases then randomized traffic
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int ESW = 170;
    localparam int MSW = 130;
    localparam logic [6:0] OP_NONE = 7'b0000000;
    localparam logic [6:0] OP_LB   = 7'b0000001;
    localparam logic [6:0] OP_LW   = 7'b0010000;
    localparam logic [6:0] OP_LWL  = 7'b0100000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if #(.ES_TO_MS_BUS_WD(ESW), .MS_TO_WS_BUS_WD(MSW)) ms_if ();

    mem_stage #(.ES_TO_MS_BUS_WD(ESW), .MS_TO_WS_BUS_WD(MSW), .DISCARD_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ms    (ms_if)
    );

    int errors = 0;
    int checks = 0;

    logic [MSW-1:0] exp_q[$];
    logic [31:0]    resp_q[$];
    logic [ESW-1:0] cur_bus;
    logic [31:0]    cur_rdata;
    bit             auto_resp = 0;
    bit             drain = 0;
    bit             man_ok = 0;
    logic [31:0]    man_rdata = '0;

    task automatic chk(input string name, input logic [MSW-1:0] act, input logic [MSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [ESW-1:0] make_bus(input logic [6:0] op, input logic mreq,
            input logic exc, input logic cp0, input logic ehi, input logic [3:0] we,
            input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc,
            input logic [52:0] hi);
        logic [ESW-1:0] b;
        b = '0;
        b[169:163] = op;
        b[162]     = mreq;
        b[161:130] = $urandom;
        b[129:77]  = hi;
        b[76]      = ehi;
        b[75]      = 1'b0;
        b[74]      = exc;
        b[73]      = cp0;
        b[72:69]   = we;
        b[68:64]   = dest;
        b[63:32]   = alu;
        b[31:0]    = pc;
        return b;
    endfunction

    // Reference: byte-lane arithmetic straight from the load rules.
    function automatic logic [31:0] model_result(input logic [6:0] op, input int a,
            input logic [31:0] d, input logic [31:0] alu);
        int unsigned b, h, ud;
        ud = d;
        b  = (ud / (2 ** (8 * a))) % 256;
        h  = (ud / (2 ** (16 * (a / 2)))) % 65536;
        if (op[0]) return (b >= 128) ? b + 32'hffffff00 : b;
        if (op[1]) return b;
        if (op[2]) return (h >= 32768) ? h + 32'hffff0000 : h;
        if (op[3]) return h;
`ifdef MEM_LWLR_EN
        if (op[5]) return ud * (2 ** (8 * (3 - a)));
        if (op[6]) return ud / (2 ** (8 * a));
        if (op[4]) return ud;
`else
        if (op[4] || op[5] || op[6]) return ud;
`endif
        return alu;
    endfunction

    function automatic logic [3:0] model_we(input logic [6:0] op, input int a,
            input logic exc, input logic [3:0] we_in);
        logic [3:0] m;
        if (exc) return 4'h0;
        if (op == 7'd0) return we_in;
`ifdef MEM_LWLR_EN
        if (op[5] || op[6]) begin
            for (int k = 0; k < 4; k++)
                m[k] = op[5] ? (k >= 3 - a) : (k <= 3 - a);
            return m;
        end
`endif
        return 4'hf;
    endfunction

    function automatic logic [MSW-1:0] expected_of(input logic [ESW-1:0] b, input logic [31:0] d);
        logic [MSW-1:0] e;
        int a;
        a = int'(b[33:32]);
        e = b[MSW-1:0];
        e[72:69] = model_we(b[169:163], a, b[74], b[72:69]);
        e[63:32] = model_result(b[169:163], a, d, b[63:32]);
        return e;
    endfunction

    task automatic drive(input logic [ESW-1:0] b, input logic [31:0] d);
        cur_bus   = b;
        cur_rdata = d;
        ms_if.es_to_ms_bus   = b;
        ms_if.es_to_ms_valid = 1'b1;
    endtask

    task automatic step();
        bit acc;
        @(negedge clk);
        acc = ms_if.es_to_ms_valid && ms_if.ms_allowin && !ms_if.flush && !reset;
        if (acc) begin
            exp_q.push_back(expected_of(cur_bus, cur_rdata));
            if (auto_resp && cur_bus[162] && !cur_bus[74]) resp_q.push_back(cur_rdata);
        end
        @(posedge clk);
        #1;
        if (acc) ms_if.es_to_ms_valid = 1'b0;
    endtask

    // Sole driver of the SRAM response; applied 2 time units after the edge.
    always @(posedge clk) begin
        #2;
        if (auto_resp) begin
            if (resp_q.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
                ms_if.data_sram_data_ok = 1'b1;
                ms_if.data_sram_rdata   = resp_q.pop_front();
            end else begin
                ms_if.data_sram_data_ok = 1'b0;
                ms_if.data_sram_rdata   = $urandom;
            end
        end else begin
            ms_if.data_sram_data_ok = man_ok;
            ms_if.data_sram_rdata   = man_rdata;
        end
    end

    logic [MSW-1:0] mon_exp;
    always @(negedge clk) begin
        if (!reset) begin
            if (ms_if.ms_to_ws_valid && ms_if.ws_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ws_unexpected: got %h required no output", ms_if.ms_to_ws_bus);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("ws_bus", ms_if.ms_to_ws_bus, mon_exp);
                end
            end
            if (ms_if.flush) exp_q.delete();
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_allowin"}, ms_if.ms_allowin, 1);
        chk({tag, "_ws_valid"}, ms_if.ms_to_ws_valid, 0);
        chk({tag, "_stall_v"}, ms_if.stall_ms_bus[9:5], 0);
        chk({tag, "_fwd_rdy"}, ms_if.forward_ms_bus[32], 0);
        chk({tag, "_exc_eret"}, ms_if.ms_exc_eret, 0);
        chk({tag, "_entryhi"}, ms_if.ms_entryhi_hazard, 0);
    endtask

    task automatic gen_random();
        int k;
        logic [6:0] op;
        logic mreq, exc;
        k    = $urandom_range(0, 8);
        op   = (k >= 1 && k <= 7) ? 7'(1 << (k - 1)) : OP_NONE;
        mreq = (k != 0);
        if (mreq && resp_q.size() >= 2) begin
            op   = OP_NONE;
            mreq = 1'b0;
        end
        exc = !mreq && ($urandom_range(0, 7) == 0);
        drive(make_bus(op, mreq, exc, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                       4'($urandom), 5'($urandom), $urandom, $urandom,
                       {21'($urandom), 32'($urandom)}), $urandom);
    endtask

    initial begin
        reset = 1'b1;
        ms_if.flush          = 1'b0;
        ms_if.ws_allowin     = 1'b1;
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.es_to_ms_bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        step();

        // ALU op: one-cycle latency
        drive(make_bus(OP_NONE, 0, 0, 0, 0, 4'hf, 5'd5, 32'h1234, 32'hbfc00000, '0), 0);
        step();
        chk("alu_valid", ms_if.ms_to_ws_valid, 1);
        chk("alu_stall", ms_if.stall_ms_bus, {1'b1, 4'hf, 5'd5});
        chk("alu_fwd", ms_if.forward_ms_bus, {1'b1, 32'h1234});
        step();
        chk("alu_done", ms_if.ms_to_ws_valid, 0);

        // lb at offset 2, data_ok two cycles after accept
        drive(make_bus(OP_LB, 1, 0, 0, 0, 4'h0, 5'd8, 32'h10000002, 32'h4, '0), 32'h80FF1122);
        step();
        chk("lb_wait_fwd", ms_if.forward_ms_bus[32], 0);
        chk("lb_wait_allowin", ms_if.ms_allowin, 0);
        step();
        chk("lb_wait2_valid", ms_if.ms_to_ws_valid, 0);
        man_ok = 1; man_rdata = 32'h80FF1122;
        step();
        man_ok = 0;
        chk("lb_valid", ms_if.ms_to_ws_valid, 1);
        chk("lb_fwd", ms_if.forward_ms_bus, {1'b1, 32'hFFFFFFFF});
        step();

        // lwl at offset 1
        drive(make_bus(OP_LWL, 1, 0, 0, 0, 4'h0, 5'd9, 32'h20000001, 32'h8, '0), 32'hAABBCCDD);
        step();
        man_ok = 1; man_rdata = 32'hAABBCCDD;
        step();
        man_ok = 0;
`ifdef MEM_LWLR_EN
        chk("lwl_result", ms_if.forward_ms_bus[31:0], 32'hCCDD0000);
        chk("lwl_we", ms_if.ms_to_ws_bus[72:69], 4'b1100);
`else
        chk("lwl_result", ms_if.forward_ms_bus[31:0], 32'hAABBCCDD);
        chk("lwl_we", ms_if.ms_to_ws_bus[72:69], 4'b1111);
`endif
        step();

        // Flush in WAIT, stale response discarded
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd3, 32'h100, 32'hc, '0), 32'h11111111);
        step();
        ms_if.flush = 1;
        step();
        ms_if.flush = 0;
        chk("flush_empty", ms_if.ms_allowin, 1);
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd4, 32'h104, 32'h10, '0), 32'h22222222);
        step();
        man_ok = 1; man_rdata = 32'h11111111;
        step();
        man_ok = 0;
        chk("discard_valid", ms_if.ms_to_ws_valid, 0);
        step();
        chk("discard_wait", ms_if.forward_ms_bus[32], 0);
        man_ok = 1; man_rdata = 32'h22222222;
        step();
        man_ok = 0;
        chk("after_discard_valid", ms_if.ms_to_ws_valid, 1);
        chk("after_discard_fwd", ms_if.forward_ms_bus, {1'b1, 32'h22222222});
        step();

        // Flush and data_ok in the same WAIT cycle: nothing left to discard
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd6, 32'h108, 32'h14, '0), 32'h55555555);
        step();
        ms_if.flush = 1; man_ok = 1; man_rdata = 32'h55555555;
        step();
        ms_if.flush = 0; man_ok = 0;
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd7, 32'h10c, 32'h18, '0), 32'h33333333);
        step();
        man_ok = 1; man_rdata = 32'h33333333;
        step();
        man_ok = 0;
        chk("same_cycle_valid", ms_if.ms_to_ws_valid, 1);
        chk("same_cycle_fwd", ms_if.forward_ms_bus, {1'b1, 32'h33333333});
        step();

        // Exception with mem_req: no wait, gr_we cleared, hazard flags raised
        drive(make_bus(OP_NONE, 1, 1, 1, 1, 4'hf, 5'd2, 32'h200, 32'h1c, '0), 0);
        step();
        chk("exc_valid", ms_if.ms_to_ws_valid, 1);
        chk("exc_eret", ms_if.ms_exc_eret, 1);
        chk("exc_entryhi", ms_if.ms_entryhi_hazard, 1);
        chk("exc_stall", ms_if.stall_ms_bus[9:5], 0);
        chk("cp0_fwd_rdy", ms_if.forward_ms_bus[32], 0);
        step();

        // Asynchronous reset in the middle of WAIT
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd1, 32'h300, 32'h20, '0), 32'h44444444);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        drive(make_bus(OP_LW, 1, 0, 0, 0, 4'h0, 5'd1, 32'h304, 32'h24, '0), 32'h44444444);
        step();
        man_ok = 1; man_rdata = 32'h44444444;
        step();
        man_ok = 0;
        chk("post_reset_valid", ms_if.ms_to_ws_valid, 1);
        step();

        // Randomized traffic against the scoreboard
        auto_resp = 1;
        for (int it = 0; it < 800; it++) begin
            ms_if.ws_allowin = ($urandom_range(0, 3) != 0);
            ms_if.flush      = ($urandom_range(0, 19) == 0) && (resp_q.size() <= 1);
            if (!ms_if.es_to_ms_valid && $urandom_range(0, 2) != 0) gen_random();
            step();
        end
        ms_if.flush          = 1'b0;
        ms_if.ws_allowin     = 1'b1;
        ms_if.es_to_ms_valid = 1'b0;
        drain = 1;
        repeat (20) step();
        chk("sb_drained", exp_q.size(), 0);
        chk("resp_drained", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
